// File: rtl/bin2bcd_serial_if.sv
// Handshake and result bundle between the datapath, the serial binary-to-BCD
// converter and the seven-segment display decoder.
interface bin2bcd_serial_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [DATA_WIDTH-1:0] valor;
    logic [31:0]           segmentos;
    logic                  neg;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    // Requester side: issues conversions and consumes the packed digits.
    modport master (
        output start, valor,
        input  segmentos, neg, overflow, busy, done
    );

    // Converter side.
    modport slave (
        input  start, valor,
        output segmentos, neg, overflow, busy, done
    );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock).
// Converts the magnitude of a signed or unsigned word into eight packed BCD
// digits for the display decoder; 4'hF is a blank digit and neg lights the
// minus sign. Results appear DATA_WIDTH+1 edges after an accepted start.
module bin2bcd_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter bit SIGNED      = 1'b1,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input logic             clock,
    input logic             reset,
    bin2bcd_serial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mag_q;
    logic [39:0]           bcd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  sign_q;
    logic [31:0]           seg_q;
    logic                  neg_q;
    logic                  ovf_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  start_sign;
    logic [DATA_WIDTH-1:0] start_mag;
    logic [39:0]           bcd_adj;
    logic [39:0]           bcd_d;
    logic [31:0]           disp_d;
    logic                  ovf_d;
    logic                  leading_d;

    // Sign and magnitude of the word offered with start; -2^(W-1) maps to 2^(W-1).
    assign start_sign = SIGNED & bus.valor[DATA_WIDTH-1];
    assign start_mag  = start_sign ? (~bus.valor + DATA_WIDTH'(1)) : bus.valor;

    // One double-dabble step: +3 on every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_d = {bcd_adj[38:0], mag_q[DATA_WIDTH-1]};
    end

    // Display formatting: overflow detection and leading-zero blanking (digit 0 always shown).
    always_comb begin
        disp_d    = bcd_q[31:0];
        ovf_d     = |bcd_q[39:32];
        leading_d = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                leading_d = 1'b0;
            end
            if (leading_d && BLANK_ZEROS) begin
                disp_d[4*i +: 4] = 4'hF;
            end
        end
        if (ovf_d) begin
            disp_d = 32'hFFFF_FFFF;
        end
    end

    // Control FSM with registered outputs; synchronous reset aborts any conversion.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
        if (reset) begin
            // NOTE: the working registers are cleared too, so a reset leaves no stale partial result.
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            seg_q   <= 32'hFFFF_FFFF;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sign_q  <= start_sign;
                        mag_q   <= start_mag;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(DATA_WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    mag_q <= {mag_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    seg_q   <= disp_d;
                    ovf_q   <= ovf_d;
                    neg_q   <= sign_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.segmentos = seg_q;
    assign bus.neg       = neg_q;
    assign bus.overflow  = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial. Three instances share clock, reset and
// stimulus: A (signed, blanking), B (signed, zeros shown), C (unsigned, blanking).
module tb_bin2bcd_serial;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] valor;

    int checks   = 0;
    int failures = 0;

    bin2bcd_serial_if #(.DATA_WIDTH(32)) u_if_a ();
    bin2bcd_serial_if #(.DATA_WIDTH(32)) u_if_b ();
    bin2bcd_serial_if #(.DATA_WIDTH(32)) u_if_c ();

    assign u_if_a.start = start;
    assign u_if_a.valor = valor;
    assign u_if_b.start = start;
    assign u_if_b.valor = valor;
    assign u_if_c.start = start;
    assign u_if_c.valor = valor;

    bin2bcd_serial #(.DATA_WIDTH(32), .SIGNED(1'b1), .BLANK_ZEROS(1'b1)) u_dut_a (
        .clock(clock), .reset(reset), .bus(u_if_a)
    );
    bin2bcd_serial #(.DATA_WIDTH(32), .SIGNED(1'b1), .BLANK_ZEROS(1'b0)) u_dut_b (
        .clock(clock), .reset(reset), .bus(u_if_b)
    );
    bin2bcd_serial #(.DATA_WIDTH(32), .SIGNED(1'b0), .BLANK_ZEROS(1'b1)) u_dut_c (
        .clock(clock), .reset(reset), .bus(u_if_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Present a value with start for one edge; returns #1 after the accepting edge.
    task automatic kick(input logic [31:0] v);
        @(negedge clock);
        start = 1'b1;
        valor = v;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges from the accepting edge until done; optionally pulse start at step inject_at.
    task automatic wait_done(output int lat, output int busy_n, output int held,
                             input int inject_at, input logic [31:0] inj_val);
        logic [31:0] seg0;
        seg0   = u_if_a.segmentos;
        lat    = 0;
        busy_n = u_if_a.busy ? 1 : 0;
        held   = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock);
            #1;
            lat++;
            start = 1'b0;
            if (u_if_a.done) break;
            if (u_if_a.busy) busy_n++;
            if (u_if_a.segmentos !== seg0) held = 0;
            if (lat == inject_at) begin
                start = 1'b1;
                valor = inj_val;
            end
        end
    endtask

    task automatic check_outputs(input string tag,
                                 input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] sc,
                                 input logic na, input logic nc, input logic oa, input logic oc);
        check({tag, " done_a"}, 32'(u_if_a.done), 32'd1);
        check({tag, " done_b"}, 32'(u_if_b.done), 32'd1);
        check({tag, " done_c"}, 32'(u_if_c.done), 32'd1);
        check({tag, " busy_low"}, 32'(u_if_a.busy), 32'd0);
        check({tag, " seg_a"}, u_if_a.segmentos, sa);
        check({tag, " seg_b"}, u_if_b.segmentos, sb);
        check({tag, " seg_c"}, u_if_c.segmentos, sc);
        check({tag, " neg_a"}, 32'(u_if_a.neg), 32'(na));
        check({tag, " neg_b"}, 32'(u_if_b.neg), 32'(na));
        check({tag, " neg_c"}, 32'(u_if_c.neg), 32'(nc));
        check({tag, " ovf_a"}, 32'(u_if_a.overflow), 32'(oa));
        check({tag, " ovf_b"}, 32'(u_if_b.overflow), 32'(oa));
        check({tag, " ovf_c"}, 32'(u_if_c.overflow), 32'(oc));
    endtask

    task automatic convert(input string tag, input logic [31:0] v,
                           input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] sc,
                           input logic na, input logic nc, input logic oa, input logic oc);
        int lat, busy_n, held;
        kick(v);
        check({tag, " busy_start"}, 32'(u_if_a.busy), 32'd1);
        wait_done(lat, busy_n, held, -1, 32'd0);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        check({tag, " hold"}, 32'(held), 32'd1);
        check_outputs(tag, sa, sb, sc, na, nc, oa, oc);
    endtask

    initial begin
        int lat, busy_n, held, spurious;
        reset = 1'b1;
        start = 1'b0;
        valor = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst seg", u_if_a.segmentos, 32'hFFFF_FFFF);
        check("rst neg", 32'(u_if_a.neg), 32'd0);
        check("rst ovf", 32'(u_if_a.overflow), 32'd0);
        check("rst busy", 32'(u_if_a.busy), 32'd0);
        check("rst done", 32'(u_if_a.done), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        //       tag        valor         seg A          seg B          seg C          negA negC ovfA ovfC
        convert("zero",    32'd0,        32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 0,   0,   0,   0);
        convert("12345",   32'd12345,    32'hFFF1_2345, 32'h0001_2345, 32'hFFF1_2345, 0,   0,   0,   0);
        convert("minus7",  32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'h0000_0007, 32'hFFFF_FFFF, 1,   0,   0,   1);
        convert("max",     32'd99999999, 32'h9999_9999, 32'h9999_9999, 32'h9999_9999, 0,   0,   0,   0);
        convert("max+1",   32'd100000000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  0,   1,   1);
        convert("minint",  32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,   0,   1,   1);
        convert("1000005", 32'd1000005,  32'hF100_0005, 32'h0100_0005, 32'hF100_0005, 0,   0,   0,   0);

        // Start pulsed mid-conversion with another value: ignored, not queued.
        kick(32'd12345);
        wait_done(lat, busy_n, held, 10, 32'd555);
        check("inject latency", 32'(lat), 32'd33);
        check_outputs("inject", 32'hFFF1_2345, 32'h0001_2345, 32'hFFF1_2345, 0, 0, 0, 0);
        @(posedge clock);
        #1;
        check("inject done_pulse", 32'(u_if_a.done), 32'd0);
        check("inject not_queued", 32'(u_if_a.busy), 32'd0);

        // Start held in the done cycle launches the next conversion immediately.
        kick(32'd10);
        wait_done(lat, busy_n, held, -1, 32'd0);
        check("b2b1 latency", 32'(lat), 32'd33);
        check_outputs("b2b1", 32'hFFFF_FF10, 32'h0000_0010, 32'hFFFF_FF10, 0, 0, 0, 0);
        start = 1'b1;
        valor = 32'hFA0A_1F01;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b2 accepted", 32'(u_if_a.busy), 32'd1);
        wait_done(lat, busy_n, held, -1, 32'd0);
        check("b2b2 latency", 32'(lat), 32'd33);
        check_outputs("b2b2", 32'h9999_9999, 32'h9999_9999, 32'hFFFF_FFFF, 1, 0, 0, 1);

        // Reset 15 cycles into a conversion aborts it.
        kick(32'd12345);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort busy", 32'(u_if_a.busy), 32'd0);
        check("abort done", 32'(u_if_a.done), 32'd0);
        check("abort seg_a", u_if_a.segmentos, 32'hFFFF_FFFF);
        check("abort seg_b", u_if_b.segmentos, 32'hFFFF_FFFF);
        check("abort neg", 32'(u_if_a.neg), 32'd0);
        spurious = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (u_if_a.done || u_if_a.busy) spurious++;
        end
        check("abort no_done", 32'(spurious), 32'd0);

        convert("after_rst", 32'd42, 32'hFFFF_FF42, 32'h0000_0042, 32'hFFFF_FF42, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_serial.md
Name: bin2bcd_serial

Overview:
Sequential binary-to-BCD converter that feeds the 8-digit seven-segment display decoder. It takes a two's-complement or unsigned result word from the datapath and converts its magnitude to eight packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. It outputs the packed digits and a sign flag in the exact format the display decoder consumes: nibble 4'hF is a blank digit, and neg drives the minus sign on the top digit.

Parameters:
DATA_WIDTH, 32, width of input word; legal range 4..32.
SIGNED, 1, 1 = input is two's complement, 0 = input is unsigned.
BLANK_ZEROS, 1, 1 = leading-zero digits are output as 4'hF (blank), 0 = shown as 4'h0.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request conversion; sampled only in IDLE.
valor  in  DATA_WIDTH  binary value; captured on the accepted start edge.
segmentos  out  32  packed BCD result; digit i is at [4i+3:4i]; digit 0 is least significant.
neg  out  1  result is negative (SIGNED=1 and valor MSB=1).
overflow  out  1  magnitude exceeded 99,999,999.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse; outputs were updated at this edge.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, segmentos=32'hFFFF_FFFF (all blank), neg=0, overflow=0, busy=0, done=0; internal shift/BCD registers cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE, start=1 at edge N:
  - Capture sign = SIGNED & valor[MSB].
  - Capture magnitude = sign ? (~valor + 1) as unsigned DATA_WIDTH bits : valor. For -2^31, the magnitude is 2^31; no loss.
  - Clear the 40-bit internal BCD accumulator (10 digits), load the bit counter with DATA_WIDTH, set busy=1, go to SHIFT.
- SHIFT, each edge:
  - Every accumulator digit >= 5 gets +3.
  - Shift {accumulator, magnitude} left by 1.
  - Decrement the counter.
  - After exactly DATA_WIDTH steps (edges N+1..N+DATA_WIDTH), go to FINISH.
- FINISH, edge N+DATA_WIDTH+1: register outputs, done=1 for one cycle, busy=0, go to IDLE.
  - overflow = accumulator digits 8 or 9 nonzero. If set, segmentos=32'hFFFF_FFFF.
  - Otherwise segmentos = accumulator digits 7..0. If BLANK_ZEROS=1, every digit above the most significant nonzero digit becomes 4'hF; digit 0 is never blanked, so value 0 shows "0".
  - neg = captured sign, including when overflow is set.
- Latency: start sampled at edge N produces results and done at edge N+DATA_WIDTH+1. Throughput is one conversion per DATA_WIDTH+2 cycles.
- busy is high from edge N through edge N+DATA_WIDTH+1; it is low again after that edge.
- start while busy is ignored and not queued; valor changes during busy have no effect.
- start in the cycle that done is high (state IDLE) is accepted normally.
- segmentos, neg and overflow hold their previous values during a conversion and change only at the FINISH edge.
- Reset asserted mid-conversion aborts it: no done pulse, outputs return to reset values.
- The +3 correction uses a 4-bit compare/add per digit; no carry crosses digit boundaries.

Test Plan:
1. Reset, then start with valor=32'd0 -> done exactly 33 edges after the start edge; segmentos=32'hFFFF_FFF0, neg=0, overflow=0; busy high for 33 cycles.
2. valor=32'd12345 -> segmentos=32'hFFF1_2345, neg=0. Rerun with BLANK_ZEROS=0 -> 32'h0001_2345.
3. valor=-7 (32'hFFFF_FFF9), SIGNED=1 -> segmentos=32'hFFFF_FFF7, neg=1. Same input with SIGNED=0 -> overflow=1, segmentos=32'hFFFF_FFFF, neg=0.
4. Boundary values:
   - valor=99,999,999 -> segmentos=32'h9999_9999, overflow=0.
   - valor=100,000,000 -> overflow=1, segmentos all F.
   - valor=32'h8000_0000 (SIGNED=1) -> overflow=1, neg=1.
5. Start pulsed again 10 cycles into a conversion with a different valor -> ignored; first result delivered on schedule, single done pulse. Start held high in the done cycle -> a second conversion starts immediately.
6. Reset asserted 15 cycles into a conversion of 12345 -> no done; segmentos=32'hFFFF_FFFF, busy=0 next cycle. A fresh start then converts correctly.
